// File: rtl/cram_unloader.sv
// Complex RAM unloader: sweeps all N locations after a transform and streams
// {real, im} samples on a valid/ready port. Optional CRAM_UNLOADER_BITREV_EN reads in bit-reversed order.
module cram_unloader #(
    parameter int unsigned vector_size = 16,
    parameter int unsigned N           = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(N)-1:0]      read_address,
    input  logic [vector_size-1:0]    mem_real,
    input  logic [vector_size-1:0]    mem_im,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [vector_size-1:0]    m_real,
    output logic [vector_size-1:0]    m_im,
    output logic [$clog2(N)-1:0]      m_index,
    output logic                      m_last
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned KW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [KW-1:0] k_next_c;
    logic          capture_c;

    // Address mapping from frame index to RAM location.
    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] idx);
        logic [AW-1:0] r;
        r = idx;
`ifdef CRAM_UNLOADER_BITREV_EN
        for (int b = 0; b < int'(AW); b++) begin
            r[b] = idx[AW-1-b];
        end
`endif
        return r;
    endfunction

    // k is one bit wider than the address so the "all fetched" value N is representable.
    assign k_next_c  = k + KW'(1);
    assign capture_c = (state == RUN) && (!m_valid || m_ready) && (k < KW'(N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k            <= '0;
            read_address <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            m_valid      <= 1'b0;
            m_real       <= '0;
            m_im         <= '0;
            m_index      <= '0;
            m_last       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        k            <= '0;
                        read_address <= map_addr('0);
                    end
                end
                RUN: begin
                    if (capture_c) begin
                        m_real  <= mem_real;
                        m_im    <= mem_im;
                        m_index <= k[AW-1:0];
                        m_last  <= (k == KW'(N - 1));
                        m_valid <= 1'b1;
                        k       <= k_next_c;
                        if (k_next_c < KW'(N)) begin
                            read_address <= map_addr(k_next_c[AW-1:0]);
                        end
                    end else if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                    end
                    // Final sample accepted: frame complete.
                    if (m_valid && m_ready && m_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cram_unloader.sv
// Self-checking bench for cram_unloader (N=8): randomized RAM contents and
// consumer backpressure checked against a frame-level reference model.
module tb_cram_unloader;

    localparam int unsigned VW = 16;
    localparam int unsigned NP = 8;
    localparam int unsigned AW = $clog2(NP);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] read_address;
    logic [VW-1:0] mem_real;
    logic [VW-1:0] mem_im;
    logic          m_valid;
    logic          m_ready;
    logic [VW-1:0] m_real;
    logic [VW-1:0] m_im;
    logic [AW-1:0] m_index;
    logic          m_last;

    logic [VW-1:0] ram_re [NP];
    logic [VW-1:0] ram_im [NP];

    int n_cmp = 0;
    int n_err = 0;

    cram_unloader #(.vector_size(VW), .N(NP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .read_address(read_address), .mem_real(mem_real), .mem_im(mem_im),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_im(m_im),
        .m_index(m_index), .m_last(m_last)
    );

    always #5 clk = ~clk;

    assign mem_real = ram_re[read_address];
    assign mem_im   = ram_im[read_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame index -> RAM location the consumer must see for that index.
    function automatic int ref_map(input int idx);
        int r;
        r = idx;
`ifdef CRAM_UNLOADER_BITREV_EN
        r = 0;
        for (int b = 0; b < int'(AW); b++) begin
            if (((idx >> b) & 1) != 0) r = r | (1 << (int'(AW) - 1 - b));
        end
`endif
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  32'(read_address), 32'd0);
        check({tag, "_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_data"},  {m_real, m_im}, 32'd0);
        check({tag, "_meta"},  {27'd0, m_index, m_last, busy}, 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
    endtask

    // mode 0: ready held high; 1: ready 1,0,0 repeating; 2: random ready.
    // abort_after > 0 stops after that many handshakes (for the reset test).
    task automatic run_frame(input int mode, input bit poke_start, input int abort_after);
        int            acc = 0;
        int            cyc = 0;
        bit            held = 1'b0;
        logic [31:0]   hold_data = '0;
        logic [3:0]    hold_meta = '0;
        int            stop_at;
        int            captured;
        stop_at = (abort_after > 0) ? abort_after : int'(NP);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("no_valid_at_E0", 32'(m_valid), 32'd0);
        while (acc < stop_at && cyc < 200) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 3) == 0;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            start = (poke_start && (cyc == 3 || cyc == 5)) ? 1'b1 : 1'b0;
            captured = acc + (m_valid ? 1 : 0);
            check("read_address", 32'(read_address),
                  32'(ref_map((captured < int'(NP)) ? captured : int'(NP) - 1)));
            check("done_low_in_run", {busy, done}, 32'b10);
            if (m_valid) begin
                if (held) begin
                    check("stable_data", {m_real, m_im}, hold_data);
                    check("stable_meta", {m_index, m_last}, hold_meta);
                end else begin
                    check("sample_real", 32'(m_real), 32'(ram_re[ref_map(acc)]));
                    check("sample_im", 32'(m_im), 32'(ram_im[ref_map(acc)]));
                    check("sample_index", 32'(m_index), 32'(acc));
                    check("sample_last", 32'(m_last), 32'(acc == int'(NP) - 1));
                end
                hold_data = {m_real, m_im};
                hold_meta = {m_index, m_last};
            end
            held = m_valid && !m_ready;
            if (m_valid && m_ready) acc++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (cyc >= 200) check("frame_timeout", 32'(acc), 32'(stop_at));
        if (abort_after == 0) begin
            if (mode == 0) check("throughput_cycles", 32'(cyc), 32'(NP + 1));
            check("done_pulse", 32'(done), 32'd1);
            check("busy_low_with_done", 32'(busy), 32'd0);
            check("valid_low_after_last", 32'(m_valid), 32'd0);
        end
    endtask

    task automatic fill_ram(input bit ramp);
        for (int i = 0; i < int'(NP); i++) begin
            ram_re[i] = ramp ? VW'(i) : VW'($urandom);
            ram_im[i] = ramp ? VW'(-i) : VW'($urandom);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        m_ready = 1'b0;
        fill_ram(1'b1);
        #23;
        check_all_zero("reset");
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", {busy, m_valid, done}, 32'd0);

        // Ramp data, full rate, then the done pulse must drop after one cycle.
        run_frame(0, 1'b0, 0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        // Backpressure pattern, with start poked during RUN.
        run_frame(1, 1'b1, 0);
        @(negedge clk);
        check("done_one_cycle_bp", 32'(done), 32'd0);

        // Back-to-back frames: start re-asserted in the done cycle.
        fill_ram(1'b0);
        run_frame(0, 1'b0, 0);
        run_frame(2, 1'b0, 0);
        run_frame(0, 1'b0, 0);
        @(negedge clk);

        // Random frames with random backpressure.
        for (int f = 0; f < 4; f++) begin
            fill_ram(1'b0);
            run_frame(2, f[0], 0);
            repeat (f) @(negedge clk);
        end
        @(negedge clk);

        // Reset mid-frame after 3 handshakes, then a clean frame.
        fill_ram(1'b0);
        run_frame(0, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        check("midreset_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_idle", {busy, m_valid}, 32'd0);
        run_frame(2, 1'b0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
